// File: rtl/acq_packer.sv
// acq_packer: multi-channel sample capture with one FIFO per channel and a
// round-robin byte serialiser.
//
// A shared prescaler produces a sample tick every pre+1 cycles. On each tick,
// every enabled channel pushes its sample into its own FIFO. When a FIFO is
// full the sample is dropped and that channel's sticky overflow flag is set.
// The serialiser empties the FIFOs one sample at a time, visiting channels
// round-robin. Each sample goes out as one frame: a header byte {4'hA, ch},
// then ceil(WIDTH/8) data bytes, most significant byte first.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   ch_data [NCH*WIDTH] channel k samples at [k*WIDTH +: WIDTH]
//   ch_en   [NCH]       per-channel capture enable
//   pre     [PREW]      sample period minus one, in clk cycles
//   clr_ovf             clears all overflow flags (a same-cycle set wins)
//   out_ready           downstream ready
//   out_valid, out_byte frame byte stream; held stable while stalled
//   overflow [NCH]      sticky sample-dropped flags
module acq_packer #(
   parameter int NCH   = 4,
   parameter int WIDTH = 12,
   parameter int DLOG2 = 4,
   parameter int PREW  = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] ch_data,
   input  logic [NCH-1:0]       ch_en,
   input  logic [PREW-1:0]      pre,
   input  logic                 clr_ovf,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [7:0]           out_byte,
   output logic [NCH-1:0]       overflow
);
   localparam int DEPTH = 1 << DLOG2;
   localparam int NB    = (WIDTH + 7) / 8;

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   // ---------------- prescaler ----------------
   // The >= compare lets a lowered pre take effect at once, even when the
   // counter is already past the new value.
   logic [PREW-1:0] pcnt_q, pcnt_d;
   logic            tick;

   assign tick   = (pcnt_q >= pre);
   assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst)
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;

   // ---------------- per-channel FIFOs ----------------
   logic [NCH-1:0]            pop, nonempty, ovf_set;
   logic [NCH-1:0][WIDTH-1:0] head;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [DLOG2-1:0] wp_q, rp_q;
      logic [DLOG2:0]   cnt_q;
      logic             push, full, accept;

      assign push        = tick & ch_en[k];
      assign full        = (cnt_q == (DLOG2+1)'(DEPTH));
      // A pop in the same cycle frees a slot, so a push into a full FIFO
      // still succeeds.
      assign accept      = push & (~full | pop[k]);
      assign ovf_set[k]  = push & full & ~pop[k];
      assign nonempty[k] = (cnt_q != '0);
      assign head[k]     = mem[rp_q];

      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (accept) wp_q <= wp_q + 1'b1;
            if (pop[k]) rp_q <= rp_q + 1'b1;
            case ({accept, pop[k]})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
         end

      always_ff @(posedge clk)
         if (accept) mem[wp_q] <= ch_data[k*WIDTH +: WIDTH];
   end

   // ---------------- overflow flags ----------------
   logic [NCH-1:0] ovf_q, ovf_d;

   assign ovf_d    = (clr_ovf ? '0 : ovf_q) | ovf_set;
   assign overflow = ovf_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) ovf_q <= '0;
      else     ovf_q <= ovf_d;

   // ---------------- round-robin arbiter ----------------
   state_t           state_q, state_d;
   logic [3:0]       ch_q, ch_d, last_q, last_d, sel;
   logic [WIDTH-1:0] samp_q, samp_d, sel_data;
   logic             bcnt_q, bcnt_d, sel_ok;

   // Prefer the lowest non-empty channel above last_q. If there is none,
   // wrap around to the lowest non-empty channel overall.
   always_comb begin : arb
      logic       hi_ok, lo_ok;
      logic [3:0] hi, lo;
      hi_ok = 1'b0; lo_ok = 1'b0; hi = '0; lo = '0;
      for (int j = NCH-1; j >= 0; j--) begin
         if (nonempty[j] && j > int'(last_q)) begin hi_ok = 1'b1; hi = 4'(j); end
         if (nonempty[j])                     begin lo_ok = 1'b1; lo = 4'(j); end
      end
      sel_ok   = hi_ok | lo_ok;
      sel      = hi_ok ? hi : lo;
      sel_data = '0;
      pop      = '0;
      for (int j = 0; j < NCH; j++) begin
         if (sel == 4'(j)) sel_data = head[j];
         pop[j] = (state_q == IDLE) && sel_ok && (sel == 4'(j));
      end
   end

   // ---------------- serialiser FSM ----------------
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         last_q  <= 4'(NCH-1);
         samp_q  <= '0;
         bcnt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
         samp_q  <= samp_d;
         bcnt_q  <= bcnt_d;
      end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      last_d  = last_q;
      samp_d  = samp_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         IDLE: if (sel_ok) begin
            state_d = HDR;
            ch_d    = sel;
            last_d  = sel;
            samp_d  = sel_data;
         end
         HDR: if (out_ready) begin
            state_d = DATA;
            bcnt_d  = 1'(NB-1);
         end
         DATA: if (out_ready) begin
            if (bcnt_q == 1'b0) state_d = IDLE;
            else                bcnt_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come straight from registers, so they hold still while stalled
   // and drop to zero as soon as reset asserts.
   always_comb begin : outs
      logic [8*NB-1:0] ext;
      ext = '0;
      ext[WIDTH-1:0] = samp_q;
      out_valid = (state_q != IDLE);
      out_byte  = 8'h00;
      case (state_q)
         HDR:  out_byte = {4'b1010, ch_q};
         DATA: out_byte = (bcnt_q && NB > 1) ? ext[8*NB-1 -: 8] : ext[7:0];
         default: out_byte = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_acq_packer.sv
module tb_acq_packer;
   localparam int NCH = 4, W = 12, DL = 4, PW = 10;
   localparam int DEPTH = 1 << DL, NB = (W + 7) / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH*W-1:0] ch_data;
   logic [NCH-1:0]   ch_en;
   logic [PW-1:0]    pre;
   logic             clr_ovf, out_ready;
   logic             out_valid;
   logic [7:0]       out_byte;
   logic [NCH-1:0]   overflow;

   logic        en1;
   logic [15:0] d16;
   logic [4:0]  d5;
   logic        v16, v5;
   logic [7:0]  b16, b5;
   logic [0:0]  o16, o5;

   acq_packer #(.NCH(NCH), .WIDTH(W), .DLOG2(DL), .PREW(PW)) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_en(ch_en), .pre(pre),
      .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(out_valid),
      .out_byte(out_byte), .overflow(overflow));

   acq_packer #(.NCH(1), .WIDTH(16), .DLOG2(DL), .PREW(PW)) u16 (
      .clk(clk), .rst(rst), .ch_data(d16), .ch_en(en1), .pre(pre),
      .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(v16),
      .out_byte(b16), .overflow(o16));

   acq_packer #(.NCH(1), .WIDTH(5), .DLOG2(DL), .PREW(PW)) u5 (
      .clk(clk), .rst(rst), .ch_data(d5), .ch_en(en1), .pre(pre),
      .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(v5),
      .out_byte(b5), .overflow(o5));

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one sample queue per channel plus the queue of bytes
   // still to send in the current frame. Each negedge it checks the DUT
   // outputs against the model, then applies what the next rising edge does.
   int             mq [NCH][$];
   int             mf [$];
   int             m_cnt = 0, m_last = NCH-1;
   logic [NCH-1:0] m_ovf = '0;
   int             obs [$], q16 [$], q5 [$];

   always @(negedge clk) begin : model
      logic           tk;
      int             popc, c, s;
      logic [NCH-1:0] set;
      if (rst) begin
         for (int k = 0; k < NCH; k++) mq[k].delete();
         mf.delete(); m_cnt = 0; m_last = NCH-1; m_ovf = '0;
      end
      chk("valid", 32'(out_valid), 32'(mf.size() > 0));
      chk("byte", 32'(out_byte), (mf.size() > 0) ? mf[0] : 0);
      chk("ovf", 32'(overflow), 32'(m_ovf));
      if (!rst) begin
         if (out_valid && out_ready) obs.push_back(int'(out_byte));
         if (v16 && out_ready) q16.push_back(int'(b16));
         if (v5 && out_ready) q5.push_back(int'(b5));
         tk = (m_cnt >= int'(pre));
         popc = -1;
         if (mf.size() == 0) begin
            for (int i = 1; i <= NCH; i++) begin
               c = (m_last + i) % NCH;
               if (popc < 0 && mq[c].size() > 0) popc = c;
            end
            if (popc >= 0) begin
               s = mq[popc].pop_front();
               mf.push_back(8'hA0 | popc);
               for (int b = NB-1; b >= 0; b--) mf.push_back((s >> (8*b)) & 255);
               m_last = popc;
            end
         end else if (out_ready) begin
            void'(mf.pop_front());
         end
         set = '0;
         if (tk)
            for (int k = 0; k < NCH; k++)
               if (ch_en[k]) begin
                  if (mq[k].size() < DEPTH) mq[k].push_back(int'(ch_data[k*W +: W]));
                  else set[k] = 1'b1;
               end
         m_ovf = (clr_ovf ? '0 : m_ovf) | set;
         m_cnt = tk ? 0 : m_cnt + 1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ch_data = '0; ch_en = '0; pre = '0; clr_ovf = 1'b0;
      out_ready = 1'b0; en1 = 1'b0; d16 = 16'h1234; d5 = 5'h1F;
      cyc(2);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_byte", 32'(out_byte), 0);
      chk("rst_ovf", 32'(overflow), 0);

      // Single channel, tick every 4 cycles.
      pre = 3; ch_en = 4'b0001; ch_data[11:0] = 12'hABC; out_ready = 1'b1;
      do_reset(); obs.delete();
      cyc(40);
      chk("A_len", 32'(obs.size() >= 9), 1);
      if (obs.size() >= 9)
         for (int f = 0; f < 3; f++) begin
            chk("A_hdr", obs[3*f], 8'hA0);
            chk("A_hi", obs[3*f+1], 8'h0A);
            chk("A_lo", obs[3*f+2], 8'hBC);
         end

      // All channels, tick every cycle: round-robin order, FIFOs saturate.
      pre = 0; ch_en = 4'b1111;
      do_reset(); obs.delete();
      for (int i = 0; i < 200; i++) begin
         ch_data = 48'({$urandom, $urandom});
         cyc(1);
      end
      chk("B_len", 32'(obs.size() >= 13), 1);
      if (obs.size() >= 13) begin
         chk("B_rr0", obs[0], 8'hA0);
         chk("B_rr1", obs[3], 8'hA1);
         chk("B_rr2", obs[6], 8'hA2);
         chk("B_rr3", obs[9], 8'hA3);
         chk("B_rr4", obs[12], 8'hA0);
      end
      chk("B_ovf", 32'(overflow), 4'hF);
      clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
      chk("B_clr_setwins", 32'(overflow), 4'hF);

      // Stall during the channel 2 header.
      ch_en = 4'b0100; pre = 3; out_ready = 1'b0; ch_data[2*W +: W] = 12'h5C3;
      do_reset();
      for (int i = 0; i < 20 && !out_valid; i++) cyc(1);
      chk("C_start", 32'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("C_hold_v", 32'(out_valid), 1);
         chk("C_hold_b", 32'(out_byte), 8'hA2);
         cyc(1);
      end
      obs.delete(); out_ready = 1'b1; cyc(4);
      chk("C_len", 32'(obs.size() >= 3), 1);
      if (obs.size() >= 3) begin
         chk("C_hdr", obs[0], 8'hA2);
         chk("C_hi", obs[1], 8'h05);
         chk("C_lo", obs[2], 8'hC3);
      end

      // Fill channel 2 while stalled: one sample sits in the frame, 16 in
      // the FIFO, and the rest are dropped.
      ch_en = 4'b0100; pre = 0; out_ready = 1'b0; ch_data = '0;
      do_reset();
      for (int j = 0; j < 20; j++) begin
         ch_data[2*W +: W] = 12'(j);
         cyc(1);
      end
      ch_en = '0;
      chk("D_ovf", 32'(overflow), 4'b0100);
      obs.delete(); out_ready = 1'b1; cyc(80);
      chk("D_len", 32'(obs.size()), 17*3);
      if (obs.size() == 17*3)
         for (int f = 0; f < 17; f++) begin
            chk("D_hdr", obs[3*f], 8'hA2);
            chk("D_data", obs[3*f+2] | (obs[3*f+1] << 8), f);
         end

      // Reset in the middle of a frame.
      ch_en = 4'b1111; pre = 0; out_ready = 1'b1;
      do_reset(); cyc(60);
      for (int i = 0; i < 20 && mf.size() != NB+1; i++) cyc(1);
      chk("E_hdr_found", 32'(mf.size()), NB+1);
      cyc(1);
      rst = 1'b1; #1;
      chk("E_valid", 32'(out_valid), 0);
      chk("E_byte", 32'(out_byte), 0);
      chk("E_ovf", 32'(overflow), 0);
      cyc(2); rst = 1'b0; obs.delete();
      cyc(10);
      chk("E_len", 32'(obs.size() > 0), 1);
      if (obs.size() > 0) chk("E_first", obs[0], 8'hA0);

      // Random traffic: pre changes mid-count, random stalls and clears,
      // occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom % 50 == 0) pre = PW'($urandom_range(0, 5));
         if ($urandom % 30 == 0) ch_en = NCH'($urandom);
         ch_data   = 48'({$urandom, $urandom});
         out_ready = ($urandom % 4) != 0;
         clr_ovf   = ($urandom % 20) == 0;
         rst       = ($urandom % 700) == 0;
         cyc(1);
      end
      rst = 1'b0; clr_ovf = 1'b0;

      // Other widths: 16-bit and 5-bit samples.
      ch_en = '0; pre = 0; out_ready = 1'b1; en1 = 1'b1;
      do_reset(); q16.delete(); q5.delete();
      cyc(8); en1 = 1'b0;
      chk("G_len16", 32'(q16.size() >= 3), 1);
      chk("G_len5", 32'(q5.size() >= 2), 1);
      if (q16.size() >= 3) begin
         chk("G16_hdr", q16[0], 8'hA0);
         chk("G16_hi", q16[1], 8'h12);
         chk("G16_lo", q16[2], 8'h34);
      end
      if (q5.size() >= 2) begin
         chk("G5_hdr", q5[0], 8'hA0);
         chk("G5_data", q5[1], 8'h1F);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
